// File: rtl/lbus_arb2.sv
// lbus_arb2: two-master round-robin arbiter onto one shared local-bus slave, one transaction at a time.
// Define LBUS_ARB2_TIMEOUT_EN to add a 255-cycle read timeout answering 32'hDEAD_BEEF.
module lbus_arb2 #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_waddr,
  input  logic [ADDR_W-1:0] m0_raddr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  input  logic              m0_wen,
  input  logic              m0_ren,
  output logic              m0_wready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic [ADDR_W-1:0] m1_waddr,
  input  logic [ADDR_W-1:0] m1_raddr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  input  logic              m1_wen,
  input  logic              m1_ren,
  output logic              m1_wready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic [ADDR_W-1:0] s_waddr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  output logic              s_wen,
  output logic [ADDR_W-1:0] s_raddr,
  output logic              s_ren,
  input  logic              s_wready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rvalid,
  output logic              timeout_err
);

  typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              req0, req1, pick;
  logic              wr_done, rd_done, tmo_hit;
  logic [DATA_W-1:0] rd_data;

  assign req0 = m0_wen | m0_ren;
  assign req1 = m1_wen | m1_ren;
  // On a tie the master not served last wins; a lone requester always wins.
  assign pick = (req0 & req1) ? ~last_grant_q : req1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    s_waddr      = '0;
    s_wdata      = '0;
    s_wstrb      = '0;
    s_wen        = 1'b0;
    s_raddr      = '0;
    s_ren        = 1'b0;
    wr_done      = 1'b0;
    rd_done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0 | req1) begin
          grant_d = pick;
          // A master asking for both is served its write first.
          state_d = (pick ? m1_wen : m0_wen) ? StWr : StRd;
        end
      end
      StWr: begin
        s_wen   = 1'b1;
        s_waddr = grant_q ? m1_waddr : m0_waddr;
        s_wdata = grant_q ? m1_wdata : m0_wdata;
        s_wstrb = grant_q ? m1_wstrb : m0_wstrb;
        if (s_wready) begin
          wr_done      = 1'b1;
          last_grant_d = grant_q;
          state_d      = StIdle;
        end
      end
      StRd: begin
        s_ren   = 1'b1;
        s_raddr = grant_q ? m1_raddr : m0_raddr;
        if (s_rvalid | tmo_hit) begin
          rd_done      = 1'b1;
          last_grant_d = grant_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m0_wready = wr_done & ~grant_q;
    m1_wready = wr_done & grant_q;
    m0_rvalid = rd_done & ~grant_q;
    m1_rvalid = rd_done & grant_q;
    m0_rdata  = m0_rvalid ? rd_data : '0;
    m1_rdata  = m1_rvalid ? rd_data : '0;
  end

`ifdef LBUS_ARB2_TIMEOUT_EN
  localparam logic [DATA_W-1:0] TimeoutData = DATA_W'(32'hDEAD_BEEF);

  logic [7:0] tmo_cnt_q;
  logic       tmo_err_q;

  // Counter is 0 in the RD entry cycle, so the hit lands 255 cycles after entry.
  assign tmo_hit = (state_q == StRd) && !s_rvalid && (tmo_cnt_q == 8'hFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= (state_q == StRd) ? tmo_cnt_q + 8'd1 : 8'd0;
      if (tmo_hit) begin
        tmo_err_q <= 1'b1;
      end
    end
  end

  assign timeout_err = tmo_err_q;
  assign rd_data     = s_rvalid ? s_rdata : TimeoutData;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
  assign rd_data     = s_rdata;
`endif

endmodule

// File: tb/tb_lbus_arb2.sv
// tb_lbus_arb2: directed scenarios plus randomized traffic against a transaction-level model.
module tb_lbus_arb2;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    wen, ren;
  logic [AW-1:0] waddr [2];
  logic [AW-1:0] raddr [2];
  logic [DW-1:0] wdata [2];
  logic [SW-1:0] wstrb [2];
  logic [1:0]    wready_o, rvalid_o;
  logic [DW-1:0] rdata_o [2];
  logic [AW-1:0] s_waddr, s_raddr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [SW-1:0] s_wstrb;
  logic          s_wen, s_ren, s_wready, s_rvalid, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lbus_arb2 #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_waddr   (waddr[0]),
    .m0_raddr   (raddr[0]),
    .m0_wdata   (wdata[0]),
    .m0_wstrb   (wstrb[0]),
    .m0_wen     (wen[0]),
    .m0_ren     (ren[0]),
    .m0_wready  (wready_o[0]),
    .m0_rdata   (rdata_o[0]),
    .m0_rvalid  (rvalid_o[0]),
    .m1_waddr   (waddr[1]),
    .m1_raddr   (raddr[1]),
    .m1_wdata   (wdata[1]),
    .m1_wstrb   (wstrb[1]),
    .m1_wen     (wen[1]),
    .m1_ren     (ren[1]),
    .m1_wready  (wready_o[1]),
    .m1_rdata   (rdata_o[1]),
    .m1_rvalid  (rvalid_o[1]),
    .s_waddr    (s_waddr),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_wen      (s_wen),
    .s_raddr    (s_raddr),
    .s_ren      (s_ren),
    .s_wready   (s_wready),
    .s_rdata    (s_rdata),
    .s_rvalid   (s_rvalid),
    .timeout_err(timeout_err)
  );

  // CSR-style slave: 8 words, byte strobes, registered rvalid that s_ren clears.
  logic [DW-1:0] mem [8];
  logic          slv_rv_q;
  logic [DW-1:0] slv_rdata_q;
  logic          rv_go, rv_mute;

  assign s_rvalid = slv_rv_q;
  assign s_rdata  = slv_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slv_rv_q    <= 1'b0;
      slv_rdata_q <= '0;
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else begin
      slv_rv_q    <= s_ren && !slv_rv_q && rv_go && !rv_mute;
      slv_rdata_q <= mem[s_raddr[4:2]];
      if (s_wen && s_wready) begin
        for (int b = 0; b < int'(SW); b++) begin
          if (s_wstrb[b]) mem[s_waddr[4:2]][8*b +: 8] <= s_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check(tag, 64'(|{s_wen, s_ren, s_waddr, s_raddr, s_wdata, s_wstrb, wready_o, rvalid_o,
                     rdata_o[0], rdata_o[1], timeout_err}), 64'd0);
  endtask

  task automatic do_reset();
    wen = '0;
    ren = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input int m, input bit rd, input int limit);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (t < limit && !(rd ? rvalid_o[m] : wready_o[m]));
  endtask

  task automatic m_write(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s);
    waddr[m] = a;
    wdata[m] = d;
    wstrb[m] = s;
    wen[m]   = 1'b1;
    wait_done(m, 1'b0, 20);
    check("m_write_done", 64'(wready_o[m]), 64'd1);
    wen[m] = 1'b0;
    @(negedge clk);
  endtask

  // Random-phase model state
  logic [DW-1:0] shadow [8];
  logic [1:0]    snap_wen, snap_ren, exp_w, exp_r;
  int            last_g, cur_m, em, got, t, n_done;
  bit            in_flight, cur_wr, prev_active, active, wr_fin, rd_fin;
  logic [2:0]    idx;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    wen = '0;
    ren = '0;
    for (int m = 0; m < 2; m++) begin
      waddr[m] = '0;
      raddr[m] = '0;
      wdata[m] = '0;
      wstrb[m] = '0;
    end
    s_wready = 1'b1;
    rv_go    = 1'b1;
    rv_mute  = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("reset_outputs");
    rst = 1'b0;
    @(negedge clk);
    check_quiet("idle_outputs");

    // Single zero-wait write from m0.
    wen[0] = 1'b1; waddr[0] = 32'h0; wdata[0] = 32'hA5A5_0F0F; wstrb[0] = 4'hF;
    @(negedge clk);
    check("wr_s_wen", 64'(s_wen), 64'd1);
    check("wr_s_wdata", 64'(s_wdata), 64'hA5A5_0F0F);
    check("wr_s_wstrb", 64'(s_wstrb), 64'hF);
    check("wr_m0_wready", 64'(wready_o), 64'b01);
    wen[0] = 1'b0;
    @(negedge clk);
    check("wr_s_wen_off", 64'(s_wen), 64'd0);
    check("wr_wready_off", 64'(wready_o), 64'd0);
    check("wr_mem", 64'(mem[0]), 64'hA5A5_0F0F);

    // Partial strobes build 32'h1234_5678 in word 0.
    m_write(0, 32'h0, 32'h1234_FFFF, 4'hC);
    m_write(0, 32'h0, 32'hFFFF_5678, 4'h3);
    check("strb_merge", 64'(mem[0]), 64'h1234_5678);

    // Single read from m1.
    ren[1] = 1'b1; raddr[1] = 32'h0;
    @(negedge clk);
    check("rd_s_ren_c1", 64'(s_ren), 64'd1);
    check("rd_early", 64'(rvalid_o), 64'd0);
    @(negedge clk);
    check("rd_s_ren_c2", 64'(s_ren), 64'd1);
    check("rd_m1_rvalid", 64'(rvalid_o), 64'b10);
    check("rd_m1_rdata", 64'(rdata_o[1]), 64'h1234_5678);
    check("rd_m0_quiet", 64'({wready_o[0], rdata_o[0]}), 64'd0);
    ren[1] = 1'b0;
    @(negedge clk);
    check("rd_s_ren_off", 64'(s_ren), 64'd0);
    check("rd_rdata_off", 64'(rdata_o[1]), 64'd0);

    // Simultaneous writes alternate starting with m0.
    do_reset();
    waddr[0] = 32'h4; wdata[0] = 32'h1111_1111; wstrb[0] = 4'hF;
    waddr[1] = 32'h8; wdata[1] = 32'h2222_2222; wstrb[1] = 4'hF;
    wen = 2'b11;
    for (int k = 0; k < 4; k++) begin
      got = -1;
      t   = 0;
      while (t < 20 && got < 0) begin
        @(negedge clk);
        t++;
        check("rr_no_overlap", 64'(&wready_o), 64'd0);
        if (wready_o[0]) got = 0;
        else if (wready_o[1]) got = 1;
      end
      check("rr_grant", 64'(got), 64'(k % 2));
    end
    wen = 2'b00;
    @(negedge clk);

    // Write-before-read for a master asking for both.
    waddr[0] = 32'hC; raddr[0] = 32'hC; wdata[0] = 32'hCAFE_F00D; wstrb[0] = 4'hF;
    wen[0] = 1'b1; ren[0] = 1'b1;
    wait_done(0, 1'b0, 20);
    check("wr_first", 64'(wready_o[0]), 64'd1);
    check("rd_not_first", 64'(rvalid_o[0]), 64'd0);
    wen[0] = 1'b0;
    wait_done(0, 1'b1, 20);
    check("rd_after_wr", 64'(rvalid_o[0]), 64'd1);
    check("rd_after_wr_data", 64'(rdata_o[0]), 64'hCAFE_F00D);
    ren[0] = 1'b0;
    @(negedge clk);

    // Reset mid-read: outputs drop at once, no pulse, tie goes to m0 again.
    raddr[0] = 32'h0; ren[0] = 1'b1;
    @(negedge clk);
    check("rst_rd_active", 64'(s_ren), 64'd1);
    rst = 1'b1;
    #1;
    check_quiet("rst_rd_outputs");
    ren[0] = 1'b0;
    @(negedge clk);
    check_quiet("rst_rd_hold");
    rst = 1'b0;
    @(negedge clk);
    check("rst_no_rvalid", 64'(rvalid_o), 64'd0);
    wen = 2'b11;
    got = -1;
    t   = 0;
    while (t < 20 && got < 0) begin
      @(negedge clk);
      t++;
      if (wready_o[0]) got = 0;
      else if (wready_o[1]) got = 1;
    end
    check("rst_tie_m0", 64'(got), 64'd0);
    wen = 2'b00;
    @(negedge clk);

`ifdef LBUS_ARB2_TIMEOUT_EN
    rv_mute = 1'b1;
    raddr[0] = 32'h0; ren[0] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rvalid_o[0] && t < 400);
    check("tmo_latency", 64'(t), 64'd256);
    check("tmo_rdata", 64'(rdata_o[0]), 64'hDEAD_BEEF);
    ren[0] = 1'b0;
    rv_mute = 1'b0;
    @(negedge clk);
    check("tmo_err_set", 64'(timeout_err), 64'd1);
    repeat (5) @(negedge clk);
    check("tmo_err_sticky", 64'(timeout_err), 64'd1);
    do_reset();
    check("tmo_err_cleared", 64'(timeout_err), 64'd0);
`else
    check("tmo_err_tied", 64'(timeout_err), 64'd0);
`endif

    // Randomized traffic with stalling slave.
    do_reset();
    for (int i = 0; i < 8; i++) shadow[i] = '0;
    last_g      = 1;
    in_flight   = 1'b0;
    prev_active = 1'b0;
    n_done      = 0;
    snap_wen    = '0;
    snap_ren    = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      active = s_wen | s_ren;
      if (active && !prev_active) begin
        check("rnd_start_req", 64'(|{snap_wen, snap_ren}), 64'd1);
        if (|{snap_wen, snap_ren}) begin
          if ((snap_wen[0] | snap_ren[0]) && (snap_wen[1] | snap_ren[1])) em = 1 - last_g;
          else em = (snap_wen[1] | snap_ren[1]) ? 1 : 0;
          cur_m     = em;
          cur_wr    = snap_wen[em];
          in_flight = 1'b1;
          check("rnd_op", 64'({s_wen, s_ren}), cur_wr ? 64'b10 : 64'b01);
          if (cur_wr) begin
            check("rnd_waddr", 64'(s_waddr), 64'(waddr[em]));
            check("rnd_wdata", 64'(s_wdata), 64'(wdata[em]));
            check("rnd_wstrb", 64'(s_wstrb), 64'(wstrb[em]));
          end else begin
            check("rnd_raddr", 64'(s_raddr), 64'(raddr[em]));
          end
        end
      end
      prev_active = active;
      wr_fin = in_flight && cur_wr && s_wready;
      rd_fin = in_flight && !cur_wr && s_rvalid;
      exp_w  = wr_fin ? (cur_m == 1 ? 2'b10 : 2'b01) : 2'b00;
      exp_r  = rd_fin ? (cur_m == 1 ? 2'b10 : 2'b01) : 2'b00;
      check("rnd_wready", 64'(wready_o), 64'(exp_w));
      check("rnd_rvalid", 64'(rvalid_o), 64'(exp_r));
      for (int m = 0; m < 2; m++) begin
        if (exp_r[m]) check("rnd_rdata", 64'(rdata_o[m]), 64'(shadow[raddr[m][4:2]]));
        else check("rnd_rdata_zero", 64'(rdata_o[m]), 64'd0);
      end
      if (wr_fin) begin
        idx = waddr[cur_m][4:2];
        for (int b = 0; b < int'(SW); b++) begin
          if (wstrb[cur_m][b]) shadow[idx][8*b +: 8] = wdata[cur_m][8*b +: 8];
        end
      end
      if (wr_fin || rd_fin) begin
        last_g    = cur_m;
        in_flight = 1'b0;
        n_done++;
      end
      snap_wen = wen;
      snap_ren = ren;

      @(posedge clk);
      #1;
      if (wr_fin) wen[cur_m] = 1'b0;
      if (rd_fin) ren[cur_m] = 1'b0;
      // Granted master may let go early; the transaction must still finish.
      if (in_flight && $urandom_range(0, 7) == 0) begin
        if (cur_wr) wen[cur_m] = 1'b0;
        else ren[cur_m] = 1'b0;
      end
      for (int m = 0; m < 2; m++) begin
        if (!wen[m] && !ren[m] && !(in_flight && cur_m == m) && $urandom_range(0, 3) == 0) begin
          got      = int'($urandom_range(0, 2));
          idx      = 3'($urandom_range(0, 7));
          waddr[m] = {27'd0, idx, 2'b00};
          raddr[m] = {27'd0, idx, 2'b00};
          wdata[m] = $urandom;
          wstrb[m] = 4'($urandom_range(1, 15));
          wen[m]   = (got != 1);
          ren[m]   = (got != 0);
        end
      end
      s_wready = ($urandom_range(0, 2) != 0);
      rv_go    = ($urandom_range(0, 2) != 0);
    end
    check("rnd_progress", 64'(n_done > 100), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
